execute_result_merge: RTL and testbench
=======================================

Name: execute_result_merge

Overview:
Parametrised merge point between the single-cycle and multi-cycle execute pipelines. It tracks in-flight multi-cycle instructions through a MC_LATENCY-deep shadow pipeline using explicit valid bits. It resolves same-cycle arrival collisions with a one-entry hold buffer and backpressure, and supports per-strand flush. It also coalesces vector comparison results into a lane mask and feeds the registered result to memory-access and bypass logic.

Parameters:
LANES, 16, vector lanes
LANE_WIDTH, 32, bits per lane
MC_LATENCY, 4, cycles from mc_issue_i to the output register (min 2)
STRAND_BITS, 2, strand id width; NSTRANDS = 2**STRAND_BITS

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
sc_valid_i  in  1  single-cycle result present
sc_ready_o  out  1  hold buffer empty; upstream may present sc_valid_i
sc_instruction_i, sc_pc_i  in  32 each  single-cycle instruction word, PC
sc_strand_i  in  STRAND_BITS  strand id
sc_has_writeback_i, sc_writeback_is_vector_i  in  1 each  writeback flags
sc_writeback_reg_i  in  5  destination register
sc_mask_i  in  LANES  lane mask
sc_result_i  in  LANES*LANE_WIDTH  single-cycle ALU result
mc_issue_i  in  1  multi-cycle instruction issued this cycle
mc_instruction_i, mc_pc_i, mc_strand_i, mc_has_writeback_i, mc_writeback_reg_i, mc_writeback_is_vector_i, mc_mask_i  in  as sc_*  issue-time metadata
mc_is_compare_i  in  1  issued op is a vector comparison
mc_result_i  in  LANES*LANE_WIDTH  multi-cycle ALU output aligned to the tail slot
flush_mask_i  in  NSTRANDS  bit s kills every strand-s entry
mc_slot_valid_o  out  MC_LATENCY-1  occupancy of shadow slots 1..MC_LATENCY-1
valid_o, instruction_o, pc_o, strand_o, has_writeback_o, writeback_reg_o, writeback_is_vector_o, mask_o, result_o  out  as inputs  registered merged result
sc_overflow_o  out  1  registered pulse: sc input dropped

Behaviour:
- Reset: all shadow-slot valids, hold valid and valid_o = 0; every output payload 0; sc_ready_o = 1; sc_overflow_o = 0. Reset overrides flush and issue in the same cycle.
- Shadow pipeline: issue at edge t enters slot 1. It advances one slot per cycle and sits in slot MC_LATENCY-1 (the tail) during cycle t+MC_LATENCY-1. The output register captures it at edge t+MC_LATENCY.
- mc_result_i is sampled only while the tail is valid.
- Single-cycle path: sc input captured at the next edge, so latency = 1.
- Candidate priority each cycle: tail > hold > sc input. Flushed candidates are removed before selection.
- Selected candidate loads the output register. If none is selected: valid_o = 0 and all payloads 0.
- Collision case 1: sc input valid, not selected, hold empty. sc input moves into hold.
- Collision case 2: sc input valid, not selected, hold full. sc input is dropped and sc_overflow_o = 1 next cycle. This is an upstream protocol violation.
- Hold drains when it wins selection. It may be refilled in the same edge.
- sc_ready_o = !hold_valid (registered state, no combinational path from inputs).
- Compare coalescing: if the tail's is_compare bit is set, result bit i = mc_result_i[i*LANE_WIDTH]. All upper bits are 0. Otherwise mc_result_i passes unchanged.
- Flush: flush_mask_i[s] clears valid for every slot, the hold entry and the sc/mc_issue inputs whose strand = s. The output register is not retroactively cleared. Other strands are unaffected, including advancement on that edge.
- Independence: mc_issue_i and sc_valid_i may assert in the same cycle; both are accepted.
- Invalid entries carry zeroed payload. Valid derives only from valid bits, never from instruction != 0.

Test Plan:
1. Single-cycle only: sc_valid_i=1, sc_result lane0=0x1234, reg 3 -> next cycle valid_o=1, result_o[31:0]=0x1234, writeback_reg_o=3.
2. Multi-cycle, MC_LATENCY=4: issue at cycle 0 -> mc_slot_valid_o = 001, 010, 100 on cycles 1-3. Output valid at cycle 4 carries the issue PC and mc_result_i.
3. Collision: tail valid and sc_valid_i=1 at cycle 3 -> cycle 4 outputs the mc entry. sc_ready_o=0 at cycle 4. Cycle 5 outputs the held sc entry. sc_ready_o=1 at cycle 5.
4. Overflow: hold full, tail valid again and sc_valid_i=1 -> that input is dropped and sc_overflow_o pulses 1 for exactly one cycle.
5. Compare: mc_is_compare_i=1, lanes 0, 5 and 15 have bit0=1 -> result_o = 0x8021, bits above 15 zero.
6. Per-strand flush: strand 1 in slot 2, strand 2 in slot 1, flush_mask_i=0010 -> the strand-1 entry never outputs; the strand-2 entry outputs on schedule. Reset asserted mid-flight -> all valids 0 next cycle, outputs zero.

Source files
------------

// File: rtl/execute_result_merge.sv
// execute_result_merge: merges single-cycle and multi-cycle execute results into
// one registered result stream. Multi-cycle ops ride a shadow pipeline of valid
// bits and metadata; a one-entry hold buffer absorbs same-cycle collisions.
module execute_result_merge #(
    parameter int LANES       = 16,
    parameter int LANE_WIDTH  = 32,
    parameter int MC_LATENCY  = 4,
    parameter int STRAND_BITS = 2,
    localparam int NSTRANDS   = 2**STRAND_BITS,
    localparam int RW         = LANES*LANE_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sc_valid_i,
    output logic                   sc_ready_o,
    input  logic [31:0]            sc_instruction_i,
    input  logic [31:0]            sc_pc_i,
    input  logic [STRAND_BITS-1:0] sc_strand_i,
    input  logic                   sc_has_writeback_i,
    input  logic                   sc_writeback_is_vector_i,
    input  logic [4:0]             sc_writeback_reg_i,
    input  logic [LANES-1:0]       sc_mask_i,
    input  logic [RW-1:0]          sc_result_i,
    input  logic                   mc_issue_i,
    input  logic [31:0]            mc_instruction_i,
    input  logic [31:0]            mc_pc_i,
    input  logic [STRAND_BITS-1:0] mc_strand_i,
    input  logic                   mc_has_writeback_i,
    input  logic [4:0]             mc_writeback_reg_i,
    input  logic                   mc_writeback_is_vector_i,
    input  logic [LANES-1:0]       mc_mask_i,
    input  logic                   mc_is_compare_i,
    input  logic [RW-1:0]          mc_result_i,
    input  logic [NSTRANDS-1:0]    flush_mask_i,
    output logic [MC_LATENCY-2:0]  mc_slot_valid_o,
    output logic                   valid_o,
    output logic [31:0]            instruction_o,
    output logic [31:0]            pc_o,
    output logic [STRAND_BITS-1:0] strand_o,
    output logic                   has_writeback_o,
    output logic [4:0]             writeback_reg_o,
    output logic                   writeback_is_vector_o,
    output logic [LANES-1:0]       mask_o,
    output logic [RW-1:0]          result_o,
    output logic                   sc_overflow_o
);
    localparam int TAIL = MC_LATENCY-1;

    typedef struct packed {
        logic [31:0]            instruction;
        logic [31:0]            pc;
        logic [STRAND_BITS-1:0] strand;
        logic                   has_wb;
        logic [4:0]             wb_reg;
        logic                   wb_vec;
        logic [LANES-1:0]       mask;
    } meta_t;

    typedef struct packed {
        meta_t meta;
        logic  cmp;
    } slot_t;

    logic [TAIL:1] vld_pipe;
    logic [TAIL:1] slot_live;
    slot_t         slot [TAIL:1];
    slot_t         iss_slot;
    meta_t         sc_meta;

    logic          hold_valid;
    meta_t         hold_meta;
    logic [RW-1:0] hold_result;

    logic          tail_v, hold_v, sc_v, iss_v;
    logic          sel_hold, sel_sc, sc_park, sc_drop;
    logic          sel_valid;
    meta_t         sel_meta;
    logic [RW-1:0] sel_result, tail_result;
    logic [LANES-1:0] cmp_bits;

    assign sc_meta  = '{sc_instruction_i, sc_pc_i, sc_strand_i, sc_has_writeback_i,
                        sc_writeback_reg_i, sc_writeback_is_vector_i, sc_mask_i};
    assign iss_slot = '{'{mc_instruction_i, mc_pc_i, mc_strand_i, mc_has_writeback_i,
                          mc_writeback_reg_i, mc_writeback_is_vector_i, mc_mask_i},
                        mc_is_compare_i};

    // A slot survives the edge unless its strand is being flushed.
    for (genvar k = 1; k <= TAIL; k++) begin : g_live
        assign slot_live[k] = vld_pipe[k] & ~flush_mask_i[slot[k].meta.strand];
    end

    // Compare coalescing: bit 0 of each lane becomes one bit of the lane mask.
    for (genvar i = 0; i < LANES; i++) begin : g_cmp
        assign cmp_bits[i] = mc_result_i[i*LANE_WIDTH];
    end
    assign tail_result = slot[TAIL].cmp ? {{(RW-LANES){1'b0}}, cmp_bits} : mc_result_i;

    assign tail_v   = slot_live[TAIL];
    assign hold_v   = hold_valid & ~flush_mask_i[hold_meta.strand];
    assign sc_v     = sc_valid_i & ~flush_mask_i[sc_strand_i];
    assign iss_v    = mc_issue_i & ~flush_mask_i[mc_strand_i];
    assign sel_hold = ~tail_v & hold_v;
    assign sel_sc   = ~tail_v & ~hold_v & sc_v;
    // Losing sc input parks in hold if hold is free after this edge, else it is lost.
    assign sc_park  = sc_v & ~sel_sc & (~hold_v | sel_hold);
    assign sc_drop  = sc_v & ~sel_sc & hold_v & ~sel_hold;

    assign sc_ready_o      = ~hold_valid;
    assign mc_slot_valid_o = vld_pipe;

    // Fixed-priority select: tail, then hold, then fresh sc input.
    always_comb begin
        sel_valid  = 1'b0;
        sel_meta   = '0;
        sel_result = '0;
        if (tail_v) begin
            sel_valid  = 1'b1;
            sel_meta   = slot[TAIL].meta;
            sel_result = tail_result;
        end else if (hold_v) begin
            sel_valid  = 1'b1;
            sel_meta   = hold_meta;
            sel_result = hold_result;
        end else if (sc_v) begin
            sel_valid  = 1'b1;
            sel_meta   = sc_meta;
            sel_result = sc_result_i;
        end
    end

    // Shadow pipeline: valid bits shift with metadata, dead slots carry zeros.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            for (int k = 1; k <= TAIL; k++) slot[k] <= '0;
        end else begin
            vld_pipe[1] <= iss_v;
            slot[1]     <= iss_v ? iss_slot : '0;
            for (int k = 2; k <= TAIL; k++) begin
                vld_pipe[k] <= slot_live[k-1];
                slot[k]     <= slot_live[k-1] ? slot[k-1] : '0;
            end
        end
    end

    // Hold buffer: refill beats drain, drain or flush empties it.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid  <= 1'b0;
            hold_meta   <= '0;
            hold_result <= '0;
        end else if (sc_park) begin
            hold_valid  <= 1'b1;
            hold_meta   <= sc_meta;
            hold_result <= sc_result_i;
        end else if (sel_hold || !hold_v) begin
            hold_valid  <= 1'b0;
            hold_meta   <= '0;
            hold_result <= '0;
        end
    end

    // Output register carries the winner, or all zeros when nothing won.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_o               <= 1'b0;
            instruction_o         <= '0;
            pc_o                  <= '0;
            strand_o              <= '0;
            has_writeback_o       <= 1'b0;
            writeback_reg_o       <= '0;
            writeback_is_vector_o <= 1'b0;
            mask_o                <= '0;
            result_o              <= '0;
            sc_overflow_o         <= 1'b0;
        end else begin
            valid_o               <= sel_valid;
            instruction_o         <= sel_meta.instruction;
            pc_o                  <= sel_meta.pc;
            strand_o              <= sel_meta.strand;
            has_writeback_o       <= sel_meta.has_wb;
            writeback_reg_o       <= sel_meta.wb_reg;
            writeback_is_vector_o <= sel_meta.wb_vec;
            mask_o                <= sel_meta.mask;
            result_o              <= sel_result;
            sc_overflow_o         <= sc_drop;
        end
    end
endmodule

// File: tb/tb_execute_result_merge.sv
// Self-checking bench for execute_result_merge: directed table, hand-written
// multi-cycle sequences and random traffic against a queue-based reference model.
module tb_execute_result_merge;
    localparam int ML = 4;

    logic clk = 0, reset = 1;
    logic sc_valid_i, sc_ready_o;
    logic [31:0] sc_instruction_i, sc_pc_i;
    logic [1:0] sc_strand_i;
    logic sc_has_writeback_i, sc_writeback_is_vector_i;
    logic [4:0] sc_writeback_reg_i;
    logic [15:0] sc_mask_i;
    logic [511:0] sc_result_i;
    logic mc_issue_i;
    logic [31:0] mc_instruction_i, mc_pc_i;
    logic [1:0] mc_strand_i;
    logic mc_has_writeback_i, mc_writeback_is_vector_i, mc_is_compare_i;
    logic [4:0] mc_writeback_reg_i;
    logic [15:0] mc_mask_i;
    logic [511:0] mc_result_i;
    logic [3:0] flush_mask_i;
    logic [2:0] mc_slot_valid_o;
    logic valid_o, has_writeback_o, writeback_is_vector_o, sc_overflow_o;
    logic [31:0] instruction_o, pc_o;
    logic [1:0] strand_o;
    logic [4:0] writeback_reg_o;
    logic [15:0] mask_o;
    logic [511:0] result_o;

    execute_result_merge #(.LANES(16), .LANE_WIDTH(32), .MC_LATENCY(ML), .STRAND_BITS(2)) dut (
        .clk(clk), .reset(reset),
        .sc_valid_i(sc_valid_i), .sc_ready_o(sc_ready_o),
        .sc_instruction_i(sc_instruction_i), .sc_pc_i(sc_pc_i), .sc_strand_i(sc_strand_i),
        .sc_has_writeback_i(sc_has_writeback_i), .sc_writeback_is_vector_i(sc_writeback_is_vector_i),
        .sc_writeback_reg_i(sc_writeback_reg_i), .sc_mask_i(sc_mask_i), .sc_result_i(sc_result_i),
        .mc_issue_i(mc_issue_i), .mc_instruction_i(mc_instruction_i), .mc_pc_i(mc_pc_i),
        .mc_strand_i(mc_strand_i), .mc_has_writeback_i(mc_has_writeback_i),
        .mc_writeback_reg_i(mc_writeback_reg_i), .mc_writeback_is_vector_i(mc_writeback_is_vector_i),
        .mc_mask_i(mc_mask_i), .mc_is_compare_i(mc_is_compare_i), .mc_result_i(mc_result_i),
        .flush_mask_i(flush_mask_i), .mc_slot_valid_o(mc_slot_valid_o),
        .valid_o(valid_o), .instruction_o(instruction_o), .pc_o(pc_o), .strand_o(strand_o),
        .has_writeback_o(has_writeback_o), .writeback_reg_o(writeback_reg_o),
        .writeback_is_vector_o(writeback_is_vector_o), .mask_o(mask_o), .result_o(result_o),
        .sc_overflow_o(sc_overflow_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] ins, pc;
        logic [1:0] strand;
        logic hwb, vec, cmp;
        logic [4:0] wreg;
        logic [15:0] mask;
        logic [511:0] res;
        int age;  // cycles since issue edge; at ML-1 it is due for output
    } ent_t;

    ent_t fl[$];
    ent_t hold_m, out_m;
    bit hold_vm, out_vm, ovf_m;

    function automatic ent_t zent();
        ent_t e;
        e.ins = 0; e.pc = 0; e.strand = 0; e.hwb = 0; e.vec = 0; e.cmp = 0;
        e.wreg = 0; e.mask = 0; e.res = 0; e.age = 0;
        return e;
    endfunction

    function automatic ent_t sc_ent();
        ent_t e = zent();
        e.ins = sc_instruction_i; e.pc = sc_pc_i; e.strand = sc_strand_i;
        e.hwb = sc_has_writeback_i; e.vec = sc_writeback_is_vector_i;
        e.wreg = sc_writeback_reg_i; e.mask = sc_mask_i; e.res = sc_result_i;
        return e;
    endfunction

    function automatic ent_t mc_ent();
        ent_t e = zent();
        e.ins = mc_instruction_i; e.pc = mc_pc_i; e.strand = mc_strand_i;
        e.hwb = mc_has_writeback_i; e.vec = mc_writeback_is_vector_i;
        e.wreg = mc_writeback_reg_i; e.mask = mc_mask_i; e.cmp = mc_is_compare_i;
        e.age = 1;
        return e;
    endfunction

    function automatic logic [511:0] coalesce(input logic [511:0] r);
        logic [511:0] o = '0;
        for (int i = 0; i < 16; i++) o[i] = r[i*32];
        return o;
    endfunction

    task automatic model_edge();
        ent_t cand, scx;
        ent_t nq[$];
        bit found, hold_eff, sc_eff, hold_sel;
        if (reset) begin
            fl.delete(); hold_vm = 0; hold_m = zent(); out_vm = 0; out_m = zent(); ovf_m = 0;
            return;
        end
        found = 0; cand = zent(); hold_sel = 0; ovf_m = 0;
        foreach (fl[i]) begin
            if (fl[i].age == ML-1 && !flush_mask_i[fl[i].strand]) begin
                cand = fl[i];
                cand.res = fl[i].cmp ? coalesce(mc_result_i) : mc_result_i;
                found = 1;
            end
        end
        hold_eff = hold_vm && !flush_mask_i[hold_m.strand];
        sc_eff = sc_valid_i && !flush_mask_i[sc_strand_i];
        scx = sc_ent();
        if (!found && hold_eff) begin cand = hold_m; found = 1; hold_sel = 1; end
        else if (!found && sc_eff) begin cand = scx; found = 1; sc_eff = 0; end
        if (!hold_eff || hold_sel) begin hold_vm = 0; hold_m = zent(); end
        if (sc_eff) begin
            if (!hold_vm) begin hold_vm = 1; hold_m = scx; end
            else ovf_m = 1;
        end
        foreach (fl[i]) begin
            ent_t e;
            e = fl[i];
            if (!flush_mask_i[e.strand] && e.age < ML-1) begin
                e.age++;
                nq.push_back(e);
            end
        end
        if (mc_issue_i && !flush_mask_i[mc_strand_i]) nq.push_back(mc_ent());
        fl = nq;
        out_vm = found;
        if (found) out_m = cand; else out_m = zent();
    endtask

    task automatic compare_all();
        logic [2:0] sv = '0;
        foreach (fl[i]) sv[fl[i].age-1] = 1'b1;
        check("valid_o", valid_o, out_vm);
        check("instruction_o", instruction_o, out_m.ins);
        check("pc_o", pc_o, out_m.pc);
        check("strand_o", strand_o, out_m.strand);
        check("has_writeback_o", has_writeback_o, out_m.hwb);
        check("writeback_reg_o", writeback_reg_o, out_m.wreg);
        check("writeback_is_vector_o", writeback_is_vector_o, out_m.vec);
        check("mask_o", mask_o, out_m.mask);
        check("result_o", result_o, out_m.res);
        check("sc_ready_o", sc_ready_o, !hold_vm);
        check("sc_overflow_o", sc_overflow_o, ovf_m);
        check("mc_slot_valid_o", mc_slot_valid_o, sv);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        sc_valid_i = 0; sc_instruction_i = 0; sc_pc_i = 0; sc_strand_i = 0;
        sc_has_writeback_i = 0; sc_writeback_is_vector_i = 0; sc_writeback_reg_i = 0;
        sc_mask_i = 0; sc_result_i = 0;
        mc_issue_i = 0; mc_instruction_i = 0; mc_pc_i = 0; mc_strand_i = 0;
        mc_has_writeback_i = 0; mc_writeback_is_vector_i = 0; mc_writeback_reg_i = 0;
        mc_mask_i = 0; mc_is_compare_i = 0; mc_result_i = 0; flush_mask_i = 0;
    endtask

    task automatic sc_put(input logic [31:0] pc, input logic [1:0] strand, input logic [31:0] lane0);
        sc_valid_i = 1; sc_pc_i = pc; sc_instruction_i = pc ^ 32'hA5A5_0000;
        sc_strand_i = strand; sc_has_writeback_i = 1; sc_writeback_reg_i = pc[6:2];
        sc_mask_i = 16'hFFFF; sc_result_i = '0; sc_result_i[31:0] = lane0;
    endtask

    task automatic mc_put(input logic [31:0] pc, input logic [1:0] strand, input logic cmp);
        mc_issue_i = 1; mc_pc_i = pc; mc_instruction_i = pc ^ 32'h5A5A_0000;
        mc_strand_i = strand; mc_has_writeback_i = 1; mc_writeback_reg_i = pc[6:2];
        mc_writeback_is_vector_i = 1; mc_mask_i = 16'h00F0; mc_is_compare_i = cmp;
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  wreg;
        logic [31:0] lane0;
        logic [1:0]  strand;
        logic [3:0]  flush;
        logic        exp_v;
        logic [4:0]  exp_reg;
        logic [31:0] exp_lane0;
    } vec_t;

    initial begin
        vec_t tbl[4];
        logic [511:0] pat;
        tbl[0] = '{32'h100, 5'd3,  32'h1234,      2'd0, 4'b0000, 1'b1, 5'd3,  32'h1234};
        tbl[1] = '{32'h104, 5'd31, 32'hFFFF_FFFF, 2'd3, 4'b0001, 1'b1, 5'd31, 32'hFFFF_FFFF};
        tbl[2] = '{32'h108, 5'd7,  32'hBEEF,      2'd2, 4'b0100, 1'b0, 5'd0,  32'h0};
        tbl[3] = '{32'h10C, 5'd0,  32'h0,         2'd1, 4'b0000, 1'b1, 5'd0,  32'h0};

        // reset state
        idle(); reset = 1;
        step(); step();
        check("reset_valid", valid_o, 1'b0);
        check("reset_ready", sc_ready_o, 1'b1);
        check("reset_slots", mc_slot_valid_o, 3'b000);
        check("reset_result", result_o, '0);
        reset = 0;

        // table: single-cycle path, latency 1, incl. flushed input
        for (int i = 0; i < 4; i++) begin
            idle();
            sc_put(tbl[i].pc, tbl[i].strand, tbl[i].lane0);
            sc_writeback_reg_i = tbl[i].wreg;
            flush_mask_i = tbl[i].flush;
            step();
            check("tbl_valid", valid_o, tbl[i].exp_v);
            check("tbl_reg", writeback_reg_o, tbl[i].exp_reg);
            check("tbl_lane0", result_o[31:0], tbl[i].exp_lane0);
        end
        idle(); step();

        // multi-cycle latency and slot occupancy
        mc_put(32'h200, 2'd0, 0); step(); idle();
        check("mc_slot_c1", mc_slot_valid_o, 3'b001); step();
        check("mc_slot_c2", mc_slot_valid_o, 3'b010); step();
        check("mc_slot_c3", mc_slot_valid_o, 3'b100);
        pat = rnd512(); mc_result_i = pat; step(); mc_result_i = 0;
        check("mc_out_valid", valid_o, 1'b1);
        check("mc_out_pc", pc_o, 32'h200);
        check("mc_out_result", result_o, pat);
        idle(); step();

        // collision: tail wins, sc parks in hold
        mc_put(32'h300, 2'd1, 0); step(); idle(); step(); step();
        sc_put(32'h340, 2'd0, 32'hCAFE); mc_result_i = 512'h77; step(); idle();
        check("coll_c4_pc", pc_o, 32'h300);
        check("coll_c4_ready", sc_ready_o, 1'b0);
        step();
        check("coll_c5_pc", pc_o, 32'h340);
        check("coll_c5_lane0", result_o[31:0], 32'hCAFE);
        check("coll_c5_ready", sc_ready_o, 1'b1);
        step();

        // overflow: two back-to-back tails with sc presented both times
        mc_put(32'h400, 2'd0, 0); step();
        mc_put(32'h404, 2'd0, 0); step(); idle(); step();
        sc_put(32'h440, 2'd3, 32'h1); step();
        sc_put(32'h444, 2'd3, 32'h2); step(); idle();
        check("ovf_pulse", sc_overflow_o, 1'b1);
        check("ovf_c5_pc", pc_o, 32'h404);
        step();
        check("ovf_clear", sc_overflow_o, 1'b0);
        check("ovf_c6_pc", pc_o, 32'h440);
        step();
        check("ovf_drained", valid_o, 1'b0);

        // compare coalescing
        mc_put(32'h500, 2'd2, 1); step(); idle(); step(); step();
        pat = '1;
        for (int i = 0; i < 16; i++) pat[i*32] = (i == 0 || i == 5 || i == 15);
        mc_result_i = pat; step(); idle();
        check("cmp_result", result_o, 512'h8021);

        // per-strand flush
        mc_put(32'h600, 2'd1, 0); step();
        mc_put(32'h604, 2'd2, 0); step(); idle();
        check("fl_before", mc_slot_valid_o, 3'b011);
        flush_mask_i = 4'b0010; step(); flush_mask_i = 0;
        check("fl_after", mc_slot_valid_o, 3'b010);
        step();
        check("fl_killed", valid_o, 1'b0);
        mc_result_i = 512'h99; step(); idle();
        check("fl_survivor_v", valid_o, 1'b1);
        check("fl_survivor_pc", pc_o, 32'h604);

        // reset mid-flight
        mc_put(32'h700, 2'd0, 0); step();
        mc_put(32'h704, 2'd1, 0); step(); idle();
        sc_put(32'h740, 2'd0, 32'h5); reset = 1; step(); idle(); reset = 0;
        check("rst_slots", mc_slot_valid_o, 3'b000);
        check("rst_valid", valid_o, 1'b0);
        check("rst_pc", pc_o, 32'h0);
        step(); step(); step();
        check("rst_no_ghost", valid_o, 1'b0);

        // random traffic against the model
        for (int c = 0; c < 600; c++) begin
            idle();
            if ($urandom_range(1) == 1 && (sc_ready_o || $urandom_range(9) == 0)) begin
                sc_put($urandom & 32'hFFFF_FFFC, 2'($urandom), $urandom);
                sc_result_i = rnd512();
                sc_writeback_is_vector_i = 1'($urandom);
                sc_mask_i = 16'($urandom);
            end
            if ($urandom_range(2) == 0) begin
                mc_put($urandom & 32'hFFFF_FFFC, 2'($urandom), 1'($urandom));
                mc_mask_i = 16'($urandom);
            end
            mc_result_i = rnd512();
            if ($urandom_range(7) == 0) flush_mask_i = 4'($urandom);
            reset = ($urandom_range(199) == 0);
            step();
        end
        reset = 0; idle(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
